hawk_att_lkp_eng: RTL
=====================

Name: hawk_att_lkp_eng

Overview:
- Parametrised successor to the single-mode page-record manager.
- Services one host-PPA lookup at a time: reads the ATT entry over an AXI4 read master, checks its status bit, and on a miss pops the free-list head for an allocation.
- Sits between the hawk control unit (lookup request/response) and the shared AXI read channel toward the HACD DRAM region.
- Single-beat INCR bursts only; one outstanding transaction.

Parameters:
- ADDR_W, 64, AXI address width
- DATA_W, 512, AXI data width (one cache line)
- ID_W, 4, AXI ID width
- AXI_ID, 0, constant ARID value driven by this block
- HPPA_W, 32, host page index width
- WAY_W, 48, way/PPA field width
- IDX_W, 32, free-list index width; index 0 means NULL
- ATT_BASE, 64'h0, ATT region byte base
- LIST_BASE, 64'h10000, free-list region byte base

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- lkp_req_i  in  1  lookup request, sampled in IDLE only
- lkp_hppa_i  in  HPPA_W  host page index, captured with the request
- lkp_busy_o  out  1  high whenever not in IDLE
- lkp_done_o  out  1  one-cycle completion pulse
- lkp_hit_o  out  1  ATT entry valid (sts=1); qualified by lkp_done_o
- lkp_alloc_o  out  1  miss resolved by a free-list pop; qualified by lkp_done_o
- lkp_way_o  out  WAY_W  hit way or allocated way; held until next request
- lkp_err_o  out  2  00 ok, 01 AXI error response, 10 free list empty
- fl_head_ld_i  in  1  load free-list head (honoured only in IDLE)
- fl_head_val_i  in  IDX_W  head value to load
- fl_head_o  out  IDX_W  current free-list head
- m_arvalid_o  out  1  AR valid
- m_araddr_o  out  ADDR_W  AR address, 64B aligned
- m_arid_o  out  ID_W  constant AXI_ID
- m_arlen_o  out  8  constant 0
- m_arsize_o  out  3  constant log2(DATA_W/8)
- m_arburst_o  out  2  constant 2'b01 (INCR)
- m_arready_i  in  1  AR ready
- m_rvalid_i  in  1  R valid
- m_rdata_i  in  DATA_W  R data
- m_rresp_i  in  2  R response
- m_rlast_i  in  1  R last
- m_rready_o  out  1  R ready

Behaviour:
- Reset: state IDLE; all outputs 0 except constants; fl_head_o = 1; lkp_way_o = 0.
- Reset mid-transaction abandons it; no response is issued.
- ATT layout:
  - EPL = DATA_W/64 entries per line.
  - Line address = ATT_BASE + (hppa / EPL) * 64; slot = hppa % EPL.
  - Entry bit 0 = sts; bits [WAY_W:1] = way; remaining bits are zpd_cnt, ignored.
- List layout:
  - LPL = DATA_W/128 entries per line; k = idx - 1.
  - Line address = LIST_BASE + (k / LPL) * 64; slot = k % LPL.
  - Entry bits [31:0] = next; bits [63:32] = prev; bits [64+WAY_W-1:64] = way.
- FSM:
  - IDLE: on lkp_req_i, capture hppa, go to ATT_AR.
  - ATT_AR: m_arvalid_o = 1 with the address stable. Hold until the arready handshake, then go to ATT_R. arvalid must not depend on arready.
  - ATT_R: m_rready_o = 1. On rvalid && rlast:
    - rresp != 0: go to DONE with err = 01.
    - Otherwise latch the slot and go to CHECK.
  - CHECK:
    - sts = 1: way = entry.way, hit = 1, go to DONE.
    - Else fl_head == 0: err = 10, go to DONE.
    - Else go to LST_AR.
  - LST_AR / LST_R: same handshake as ATT_AR / ATT_R, using the head address.
    - On a good response: way = list.way, head <= list.next, alloc = 1.
    - On an error response: err = 01 and head is unchanged.
  - DONE: pulse lkp_done_o for one cycle, return to IDLE.
- Latency with zero-wait AXI:
  - Hit: 5 cycles from req to done.
  - Miss with allocation: 7 cycles.
- rvalid with rlast = 0 is an illegal burst; it is treated as an error (01).
- lkp_req_i while busy is ignored; the requester must wait for lkp_done_o.
- fl_head_ld_i while busy is ignored.
- lkp_req_i and fl_head_ld_i in the same IDLE cycle: the load takes effect first, and the lookup uses the new head.

Optional Feature:
- Macro HAWK_ATT_LKP_CACHE_EN.
- Defined:
  - A one-entry register stores {hppa, way} of the last hit.
  - A request matching that hppa skips the AXI read and goes IDLE -> DONE with hit = 1, 2-cycle latency.
  - Any allocation or fl_head_ld_i invalidates the entry.
- Undefined: every lookup reads ATT.

Test Plan:
- Reset, then lkp_req_i with hppa = 9. Expect araddr = ATT_BASE + 64 and slot 1. Return slot 1 = {way = 48'h123, sts = 1}. Expect done at cycle 5 with hit = 1, way = 48'h123, err = 00.
- hppa = 3 with sts = 0, head = 1. Expect a second AR at LIST_BASE. Return slot 0 with next = 2, way = 48'h500. Expect alloc = 1, way = 48'h500, fl_head_o = 2.
- Load head = 0, then a miss. Expect no list AR, err = 10, fl_head_o stays 0.
- Hold arready low for 6 cycles. Expect arvalid and araddr stable throughout; single handshake; correct result after.
- ATT R returns rresp = 2'b10. Expect err = 01, hit = 0, alloc = 0, head unchanged. Assert reset during LST_R: expect IDLE, fl_head_o = 1, no done pulse.
- With HAWK_ATT_LKP_CACHE_EN: repeat hppa = 9 after a hit. Expect no arvalid and done 2 cycles after req.

Source files
------------

// File: rtl/hawk_att_lkp_eng.sv
// hawk_att_lkp_eng
// ----------------
// Services one host-PPA lookup at a time against the Address Translation
// Table (ATT) in the HACD DRAM region.
//
// For each lookup the block issues a single-beat AXI4 read of the ATT line
// and tests the status bit of the entry. On a miss it reads the free-list
// head entry with a second single-beat read, then pops that entry. There is
// never more than one AXI transaction outstanding.
//
// Optional build macro: HAWK_ATT_LKP_CACHE_EN
//   When defined, a one-entry {hppa, way} cache holds the last ATT hit.
//   A repeat request for that hppa completes without any AXI traffic.
//   The cache is invalidated by any allocation or by any head load.
//
// Ports:
//   clk_i, rst_ni        clock; asynchronous active-low reset
//   lkp_req_i/hppa_i     lookup request and host page index (sampled in IDLE)
//   lkp_busy_o           high whenever the engine is not idle
//   lkp_done_o           one-cycle completion pulse
//   lkp_hit_o/alloc_o    result flags, qualified by lkp_done_o
//   lkp_way_o            hit or allocated way, held until the next request
//   lkp_err_o            00 ok, 01 AXI error / bad burst, 10 free list empty
//   fl_head_ld_i/val_i   free-list head load (honoured in IDLE only)
//   fl_head_o            current free-list head (0 = NULL)
//   m_ar*, m_r*          AXI4 read-address and read-data channels (master side)
module hawk_att_lkp_eng #(
    parameter int          ADDR_W    = 64,
    parameter int          DATA_W    = 512,
    parameter int          ID_W      = 4,
    parameter int          AXI_ID    = 0,
    parameter int          HPPA_W    = 32,
    parameter int          WAY_W     = 48,
    parameter int          IDX_W     = 32,
    parameter logic [63:0] ATT_BASE  = 64'h0,
    parameter logic [63:0] LIST_BASE = 64'h10000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              lkp_req_i,
    input  logic [HPPA_W-1:0] lkp_hppa_i,
    output logic              lkp_busy_o,
    output logic              lkp_done_o,
    output logic              lkp_hit_o,
    output logic              lkp_alloc_o,
    output logic [WAY_W-1:0]  lkp_way_o,
    output logic [1:0]        lkp_err_o,
    input  logic              fl_head_ld_i,
    input  logic [IDX_W-1:0]  fl_head_val_i,
    output logic [IDX_W-1:0]  fl_head_o,
    output logic              m_arvalid_o,
    output logic [ADDR_W-1:0] m_araddr_o,
    output logic [ID_W-1:0]   m_arid_o,
    output logic [7:0]        m_arlen_o,
    output logic [2:0]        m_arsize_o,
    output logic [1:0]        m_arburst_o,
    input  logic              m_arready_i,
    input  logic              m_rvalid_i,
    input  logic [DATA_W-1:0] m_rdata_i,
    input  logic [1:0]        m_rresp_i,
    input  logic              m_rlast_i,
    output logic              m_rready_o
);

    localparam int EPL   = DATA_W / 64;    // ATT entries per line
    localparam int EPL_W = $clog2(EPL);
    localparam int LPL   = DATA_W / 128;   // free-list entries per line
    localparam int LPL_W = $clog2(LPL);

    typedef enum logic [2:0] {
        S_IDLE, S_ATT_AR, S_ATT_R, S_CHECK, S_LST_AR, S_LST_R, S_DONE
    } state_t;

    state_t             r_state, w_state_next;
    logic [HPPA_W-1:0]  r_hppa;
    logic               r_att_sts;
    logic [WAY_W-1:0]   r_att_way;
    logic [IDX_W-1:0]   r_fl_head;
    logic [WAY_W-1:0]   r_way;
    logic               r_hit, r_alloc;
    logic [1:0]         r_err;

    // Slice every entry slot out of the returned line so the selected
    // slot is a plain array index.
    logic               w_att_sts_arr [EPL];
    logic [WAY_W-1:0]   w_att_way_arr [EPL];
    logic [IDX_W-1:0]   w_lst_next_arr[LPL];
    logic [WAY_W-1:0]   w_lst_way_arr [LPL];

    for (genvar gi = 0; gi < EPL; gi++) begin : g_att_slot
        assign w_att_sts_arr[gi] = m_rdata_i[gi*64];
        assign w_att_way_arr[gi] = m_rdata_i[gi*64+1 +: WAY_W];
    end
    for (genvar gi = 0; gi < LPL; gi++) begin : g_lst_slot
        assign w_lst_next_arr[gi] = m_rdata_i[gi*128 +: IDX_W];
        assign w_lst_way_arr[gi]  = m_rdata_i[gi*128+64 +: WAY_W];
    end

    // zpd_cnt and the prev link are never consumed.
    logic w_unused_rdata;
    assign w_unused_rdata = ^m_rdata_i;

    logic [EPL_W-1:0]  w_att_slot;
    logic [IDX_W-1:0]  w_lst_k;
    logic [LPL_W-1:0]  w_lst_slot;
    logic [ADDR_W-1:0] w_att_addr, w_lst_addr;
    logic              w_req_go, w_r_bad, w_c_hit;
    logic [WAY_W-1:0]  w_c_way;

    assign w_att_slot = r_hppa[EPL_W-1:0];
    assign w_lst_k    = r_fl_head - IDX_W'(1);
    assign w_lst_slot = w_lst_k[LPL_W-1:0];
    assign w_att_addr = ADDR_W'(ATT_BASE)  + (ADDR_W'(r_hppa  >> EPL_W) << 6);
    assign w_lst_addr = ADDR_W'(LIST_BASE) + (ADDR_W'(w_lst_k >> LPL_W) << 6);
    assign w_req_go   = (r_state == S_IDLE) && lkp_req_i;
    // A beat without rlast on a single-beat burst is treated like an error.
    assign w_r_bad    = (m_rresp_i != 2'b00) || !m_rlast_i;

`ifdef HAWK_ATT_LKP_CACHE_EN
    logic              r_c_valid;
    logic [HPPA_W-1:0] r_c_hppa;
    logic [WAY_W-1:0]  r_c_way;

    // A head load in the same cycle invalidates the entry, so it cannot hit.
    assign w_c_hit = r_c_valid && !fl_head_ld_i && (r_c_hppa == lkp_hppa_i);
    assign w_c_way = w_c_hit ? r_c_way : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_c_valid <= 1'b0;
            r_c_hppa  <= '0;
            r_c_way   <= '0;
        end else if (r_state == S_IDLE && fl_head_ld_i) begin
            r_c_valid <= 1'b0;
        end else if (r_state == S_CHECK && r_att_sts) begin
            r_c_valid <= 1'b1;
            r_c_hppa  <= r_hppa;
            r_c_way   <= r_att_way;
        end else if (r_state == S_LST_R && m_rvalid_i && !w_r_bad) begin
            r_c_valid <= 1'b0;
        end
    end
`else
    assign w_c_hit = 1'b0;
    assign w_c_way = '0;
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (lkp_req_i) w_state_next = w_c_hit ? S_DONE : S_ATT_AR;
            S_ATT_AR: if (m_arready_i) w_state_next = S_ATT_R;
            S_ATT_R:  if (m_rvalid_i) w_state_next = w_r_bad ? S_DONE : S_CHECK;
            S_CHECK:  w_state_next = (r_att_sts || r_fl_head == '0) ? S_DONE : S_LST_AR;
            S_LST_AR: if (m_arready_i) w_state_next = S_LST_R;
            S_LST_R:  if (m_rvalid_i) w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state. The address comes from registers only,
    // so it is stable for the whole time arvalid is held.
    always_comb begin
        m_arvalid_o = (r_state == S_ATT_AR) || (r_state == S_LST_AR);
        m_rready_o  = (r_state == S_ATT_R)  || (r_state == S_LST_R);
        lkp_busy_o  = (r_state != S_IDLE);
        lkp_done_o  = (r_state == S_DONE);
        m_araddr_o  = '0;
        if (r_state == S_ATT_AR) m_araddr_o = w_att_addr;
        if (r_state == S_LST_AR) m_araddr_o = w_lst_addr;
    end

    assign m_arid_o    = ID_W'(AXI_ID);
    assign m_arlen_o   = 8'd0;
    assign m_arsize_o  = 3'($clog2(DATA_W / 8));
    assign m_arburst_o = 2'b01;

    // Datapath. The head load is applied before any use of the head, so a
    // request arriving with a load in the same cycle sees the new head.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hppa    <= '0;
            r_att_sts <= 1'b0;
            r_att_way <= '0;
            r_fl_head <= IDX_W'(1);
            r_way     <= '0;
            r_hit     <= 1'b0;
            r_alloc   <= 1'b0;
            r_err     <= 2'b00;
        end else begin
            if (r_state == S_IDLE && fl_head_ld_i) r_fl_head <= fl_head_val_i;
            if (w_req_go) begin
                r_hppa  <= lkp_hppa_i;
                r_hit   <= w_c_hit;
                r_way   <= w_c_way;
                r_alloc <= 1'b0;
                r_err   <= 2'b00;
            end
            case (r_state)
                S_ATT_R: if (m_rvalid_i) begin
                    if (w_r_bad) begin
                        r_err <= 2'b01;
                    end else begin
                        r_att_sts <= w_att_sts_arr[w_att_slot];
                        r_att_way <= w_att_way_arr[w_att_slot];
                    end
                end
                S_CHECK: begin
                    if (r_att_sts) begin
                        r_hit <= 1'b1;
                        r_way <= r_att_way;
                    end else if (r_fl_head == '0) begin
                        r_err <= 2'b10;
                    end
                end
                S_LST_R: if (m_rvalid_i) begin
                    if (w_r_bad) begin
                        r_err <= 2'b01;
                    end else begin
                        r_way     <= w_lst_way_arr[w_lst_slot];
                        r_fl_head <= w_lst_next_arr[w_lst_slot];
                        r_alloc   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign lkp_hit_o   = r_hit;
    assign lkp_alloc_o = r_alloc;
    assign lkp_way_o   = r_way;
    assign lkp_err_o   = r_err;
    assign fl_head_o   = r_fl_head;

endmodule
